// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder/decoder pair: default table
// geometry and the decoder FSM state encoding.
package huffman_pkg;

    localparam int SYM_NUM_DEF = 6;
    localparam int CODE_W_DEF  = 8;
    localparam int MAX_LEN_DEF = 6;

    // IDLE: no table loaded, incoming bits are dropped.
    // RUN:  table loaded, bits are shifted in and matched.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } hd_state_t;

endpackage

// File: rtl/huffman_match.sv
// One code-table entry comparator. A hit requires the entry's mask to cover
// exactly the number of bits collected so far and the masked shift register
// to equal the stored code. A zero mask marks an unused entry and never hits.
module huffman_match
    import huffman_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic [CODE_W-1:0] hc,
    input  logic [CODE_W-1:0] m,
    input  logic [CODE_W-1:0] sr_new,
    input  logic [LEN_W-1:0]  len_new,
    output logic              hit
);

    logic [CODE_W-1:0] len_mask;

    // Build 2^len_new - 1 and compare length and code bits in one step.
    always_comb begin
        len_mask = (CODE_W'(1) << len_new) - CODE_W'(1);
        hit      = (m != '0) && (m == len_mask) && ((sr_new & m) == hc);
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder. A code_valid pulse loads up to six (code, mask)
// pairs; afterwards each qualified input bit is shifted in MSB-first and the
// post-shift prefix is matched against every table entry. A match emits the
// symbol one cycle later; a prefix reaching MAX_LEN bits without a match
// emits an error pulse instead. Either outcome restarts prefix collection.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int SYM_NUM = SYM_NUM_DEF,
    parameter int CODE_W  = CODE_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              table_rdy,
    output logic              sym_valid,
    output logic [7:0]        sym_data,
    output logic              err,
    output logic [7:0]        sym_cnt
);

    localparam int LEN_W = $clog2(CODE_W + 1);

    hd_state_t         state, state_next;
    logic              do_load, do_shift;

    logic [CODE_W-1:0] hc_in [6];
    logic [CODE_W-1:0] m_in  [6];
    logic [CODE_W-1:0] hc_q  [SYM_NUM];
    logic [CODE_W-1:0] m_q   [SYM_NUM];

    logic [CODE_W-1:0] sr, sr_new;
    logic [LEN_W-1:0]  len, len_new;
    logic [SYM_NUM-1:0] hit_vec;
    logic              hit_any;
    logic [7:0]        hit_sym;

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: any load enters (or re-enters) RUN; only reset leaves it.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        if (code_valid) state_next = RUN;
    end

    // FSM outputs: a load always wins over a same-cycle bit.
    always_comb begin
        do_load  = code_valid;
        do_shift = (state == RUN) && bit_valid && !code_valid;
    end

    // Post-shift prefix, evaluated combinationally for matching.
    always_comb begin
        sr_new  = (sr << 1) | CODE_W'(bit_in);
        len_new = len + LEN_W'(1);
    end

    // One comparator per table entry.
    for (genvar i = 0; i < SYM_NUM; i++) begin : g_match
        huffman_match #(
            .CODE_W (CODE_W),
            .LEN_W  (LEN_W)
        ) u_match (
            .hc      (hc_q[i]),
            .m       (m_q[i]),
            .sr_new  (sr_new),
            .len_new (len_new),
            .hit     (hit_vec[i])
        );
    end

    // Priority select: scan downward so the lowest matching index is kept.
    always_comb begin
        hit_any = 1'b0;
        hit_sym = '0;
        for (int i = SYM_NUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_sym = 8'(i + 1);
            end
        end
    end

    // Code table storage.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the table is small and its cleared contents are part of the
        // defined reset state, so it is reset like ordinary registers rather
        // than left uninitialised like a RAM.
        if (reset) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                hc_q[i] <= '0;
                m_q[i]  <= '0;
            end
        end else if (do_load) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                hc_q[i] <= hc_in[i];
                m_q[i]  <= m_in[i];
            end
        end
    end

    // Prefix collection, symbol/error pulses and the symbol counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr        <= '0;
            len       <= '0;
            table_rdy <= 1'b0;
            sym_valid <= 1'b0;
            sym_data  <= '0;
            err       <= 1'b0;
            sym_cnt   <= '0;
        end else begin
            sym_valid <= 1'b0;
            err       <= 1'b0;
            if (do_load) begin
                sr        <= '0;
                len       <= '0;
                sym_cnt   <= '0;
                table_rdy <= 1'b1;
            end else if (do_shift) begin
                if (hit_any) begin
                    sr        <= '0;
                    len       <= '0;
                    sym_valid <= 1'b1;
                    sym_data  <= hit_sym;
                    sym_cnt   <= sym_cnt + 8'd1;
                end else if (len_new == LEN_W'(MAX_LEN)) begin
                    sr  <= '0;
                    len <= '0;
                    err <= 1'b1;
                end else begin
                    sr  <= sr_new;
                    len <= len_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: table load, single and multi-bit
// codes, error on over-long prefix, load/bit collision, gaps, priority,
// counter wrap and reset behaviour.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       code_valid;
    logic [7:0] hc_tb [6];
    logic [7:0] m_tb  [6];
    logic       bit_valid;
    logic       bit_in;
    logic       table_rdy;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       err;
    logic [7:0] sym_cnt;

    int errors = 0;
    int checks = 0;

    // Tables packed as {entry6, ..., entry1}.
    localparam logic [47:0] STD_HC = {8'd31, 8'd30, 8'd14, 8'd6, 8'd2, 8'd0};
    localparam logic [47:0] STD_M  = {8'd31, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1};
    localparam logic [47:0] NO6_M  = {8'd0,  8'd31, 8'd15, 8'd7, 8'd3, 8'd1};
    localparam logic [47:0] DUP_HC = {8'd0,  8'd0,  8'd0,  8'd0, 8'd1, 8'd1};
    localparam logic [47:0] DUP_M  = {8'd0,  8'd0,  8'd0,  8'd0, 8'd1, 8'd1};

    always #5 clk = ~clk;

    huffman_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc_tb[0]),
        .HC2        (hc_tb[1]),
        .HC3        (hc_tb[2]),
        .HC4        (hc_tb[3]),
        .HC5        (hc_tb[4]),
        .HC6        (hc_tb[5]),
        .M1         (m_tb[0]),
        .M2         (m_tb[1]),
        .M3         (m_tb[2]),
        .M4         (m_tb[3]),
        .M5         (m_tb[4]),
        .M6         (m_tb[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .table_rdy  (table_rdy),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .err        (err),
        .sym_cnt    (sym_cnt)
    );

    // Inputs change on the falling edge; after each call the registered
    // results of that cycle are visible and stable for sampling.
    task automatic load_table(input logic [47:0] hcs, input logic [47:0] ms,
                              input logic with_bit, input logic b);
        for (int i = 0; i < 6; i++) begin
            hc_tb[i] = hcs[8*i +: 8];
            m_tb[i]  = ms[8*i +: 8];
        end
        code_valid = 1'b1;
        bit_valid  = with_bit;
        bit_in     = b;
        @(negedge clk);
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (table_rdy !== 1'b0) begin errors++; $display("FAIL reset_table_rdy: got %b want 0", table_rdy); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
        checks++; if (sym_data !== 8'd0) begin errors++; $display("FAIL reset_sym_data: got %0d want 0", sym_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (sym_cnt !== 8'd0) begin errors++; $display("FAIL reset_sym_cnt: got %0d want 0", sym_cnt); end
    endtask

    task automatic test_idle_ignored;
        // Bit 0 would decode symbol 1 if the idle state did not drop it.
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL idle_sym_valid: got %b want 0", sym_valid); end
        checks++; if (table_rdy !== 1'b0) begin errors++; $display("FAIL idle_table_rdy: got %b want 0", table_rdy); end
        send_bit(1'b1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", err); end
        checks++; if (sym_cnt !== 8'd0) begin errors++; $display("FAIL idle_sym_cnt: got %0d want 0", sym_cnt); end
    endtask

    task automatic test_single;
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        checks++; if (table_rdy !== 1'b1) begin errors++; $display("FAIL single_table_rdy: got %b want 1", table_rdy); end
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL single_sym_valid: got %b want 1", sym_valid); end
        checks++; if (sym_data !== 8'd1) begin errors++; $display("FAIL single_sym_data: got %0d want 1", sym_data); end
        checks++; if (sym_cnt !== 8'd1) begin errors++; $display("FAIL single_sym_cnt: got %0d want 1", sym_cnt); end
        @(negedge clk);
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end: got %b want 0", sym_valid); end
    endtask

    task automatic test_multi;
        logic [4:0] six_bits = 5'b11111;
        int         seen_err = 0;
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        checks++; if (sym_cnt !== 8'd0) begin errors++; $display("FAIL multi_cnt_cleared: got %0d want 0", sym_cnt); end
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL multi_early_valid: got %b want 0", sym_valid); end
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd3) begin errors++; $display("FAIL multi_sym3: got valid=%b data=%0d want valid=1 data=3", sym_valid, sym_data); end
        for (int i = 4; i >= 0; i--) begin
            send_bit(six_bits[i]);
            if (err) seen_err++;
            if (i != 0) begin
                checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL multi_mid_valid_%0d: got %b want 0", i, sym_valid); end
            end
        end
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd6) begin errors++; $display("FAIL multi_sym6: got valid=%b data=%0d want valid=1 data=6", sym_valid, sym_data); end
        checks++; if (sym_cnt !== 8'd2) begin errors++; $display("FAIL multi_sym_cnt: got %0d want 2", sym_cnt); end
        checks++; if (seen_err !== 0) begin errors++; $display("FAIL multi_no_err: got %0d err pulses want 0", seen_err); end
    endtask

    task automatic test_err;
        load_table(STD_HC, NO6_M, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            checks++; if (err !== 1'b0 || sym_valid !== 1'b0) begin errors++; $display("FAIL err_early_%0d: got err=%b valid=%b want 0 0", i, err, sym_valid); end
        end
        send_bit(1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", err); end
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL err_no_sym: got %b want 0", sym_valid); end
        checks++; if (sym_cnt !== 8'd0) begin errors++; $display("FAIL err_sym_cnt: got %0d want 0", sym_cnt); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b want 0", err); end
        // Prefix must have been cleared: a lone 0 is symbol 1.
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd1) begin errors++; $display("FAIL err_restart: got valid=%b data=%0d want valid=1 data=1", sym_valid, sym_data); end
    endtask

    task automatic test_load_collision;
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        // Kept prefix plus this bit would give 110 = symbol 3.
        load_table(STD_HC, STD_M, 1'b1, 1'b0);
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL collide_no_sym: got %b want 0", sym_valid); end
        send_bit(1'b1);
        checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL collide_partial: got %b want 0", sym_valid); end
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd2) begin errors++; $display("FAIL collide_sym2: got valid=%b data=%0d want valid=1 data=2", sym_valid, sym_data); end
    endtask

    task automatic test_gap;
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (sym_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL gap_idle_%0d: got valid=%b err=%b want 0 0", i, sym_valid, err); end
        end
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd2) begin errors++; $display("FAIL gap_sym2: got valid=%b data=%0d want valid=1 data=2", sym_valid, sym_data); end
        @(negedge clk);
        checks++; if (sym_valid !== 1'b0 || sym_data !== 8'd2) begin errors++; $display("FAIL gap_hold: got valid=%b data=%0d want valid=0 data=2", sym_valid, sym_data); end
    endtask

    task automatic test_priority;
        load_table(DUP_HC, DUP_M, 1'b0, 1'b0);
        send_bit(1'b1);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd1) begin errors++; $display("FAIL prio_lowest: got valid=%b data=%0d want valid=1 data=1", sym_valid, sym_data); end
    endtask

    task automatic test_cnt_wrap;
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) send_bit(1'b0);
        checks++; if (sym_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", sym_cnt); end
        send_bit(1'b0);
        checks++; if (sym_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", sym_cnt); end
    endtask

    task automatic test_reset_mid;
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 reset = 1'b1;
        #1;
        checks++; if (table_rdy !== 1'b0 || sym_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got rdy=%b valid=%b err=%b want 0 0 0", table_rdy, sym_valid, err); end
        checks++; if (sym_data !== 8'd0 || sym_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_data: got data=%0d cnt=%0d want 0 0", sym_data, sym_cnt); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // Back in IDLE: a 0 must not decode without a fresh load.
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b0 || table_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got valid=%b rdy=%b want 0 0", sym_valid, table_rdy); end
        load_table(STD_HC, STD_M, 1'b0, 1'b0);
        send_bit(1'b0);
        checks++; if (sym_valid !== 1'b1 || sym_data !== 8'd1) begin errors++; $display("FAIL mid_reset_reload: got valid=%b data=%0d want valid=1 data=1", sym_valid, sym_data); end
    endtask

    // Both pulses high together is never legal.
    always @(negedge clk) begin
        if (!reset && sym_valid && err) begin
            errors++;
            $display("FAIL exclusive_pulses: got sym_valid=1 err=1 want not both");
        end
    end

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hc_tb[i] = '0;
            m_tb[i]  = '0;
        end
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b0;
        @(negedge clk);
        test_idle_ignored;
        test_single;
        test_multi;
        test_err;
        test_load_collision;
        test_gap;
        test_priority;
        test_cnt_wrap;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL expose parameter SYM_NUM, default 6, number of symbols (values 1..SYM_NUM).
REQ-002 SHALL expose parameter CODE_W, default 8, width of each code and mask word.
REQ-003 SHALL expose parameter MAX_LEN, default 6, bit count at which an unmatched prefix is declared an error.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 code_valid  input  1  one-cycle pulse; HC1..HC6/M1..M6 are valid for table load.
REQ-007 HC1..HC6  input  8 each  code words, LSB-aligned; the first transmitted bit is bit L-1.
REQ-008 M1..M6  input  8 each  masks of form 2^L-1 (L = code length); 0 = symbol unused.
REQ-009 bit_valid  input  1  bit_in qualifier, at most one bit per cycle.
REQ-010 bit_in  input  1  serial coded bit, MSB of each code first.
REQ-011 table_rdy  output  1  high once a table is loaded.
REQ-012 sym_valid  output  1  one-cycle pulse, decoded symbol on sym_data.
REQ-013 sym_data  output  8  decoded symbol value 1..6.
REQ-014 err  output  1  one-cycle pulse, no code matched within MAX_LEN bits.
REQ-015 sym_cnt  output  8  count of symbols decoded since the last table load; wraps 255->0.

Function
REQ-016 SHALL implement FSM states IDLE (no table) and RUN (table loaded, decoding).
REQ-017 IDLE->RUN on code_valid; RUN->RUN on code_valid (reload); no other transitions except reset.
REQ-018 On code_valid SHALL register all 12 words, clear shift register, length counter and sym_cnt; table_rdy=1 next cycle.
REQ-019 In IDLE, bit_valid SHALL be ignored.
REQ-020 In RUN, each bit_valid SHALL shift: sr <= {sr[CODE_W-2:0], bit_in}; len <= len+1.
REQ-021 Match for symbol i SHALL be: M_i == (2^len_new - 1) and (sr_new & M_i) == HC_i, evaluated on the post-shift value.
REQ-022 On match SHALL assert sym_valid=1 and sym_data=i in the cycle after the completing bit (1-cycle latency), clear sr and len, and increment sym_cnt.
REQ-023 Masks of 0 SHALL never match; if several match (non-prefix-free table), lowest index wins.
REQ-024 If len_new == MAX_LEN with no match, SHALL pulse err next cycle, clear sr and len; sym_cnt unchanged.
REQ-025 code_valid and bit_valid in the same cycle: load wins, bit discarded, partial prefix lost.
REQ-026 Gaps in bit_valid SHALL hold sr/len; decoding resumes with the next valid bit.
REQ-027 sym_valid and err SHALL never be high together; sym_data holds its last value when sym_valid=0.

Reset
REQ-028 reset SHALL force IDLE, table words=0, sr=0, len=0, table_rdy=0, sym_valid=0, sym_data=0, err=0, sym_cnt=0.
REQ-029 Reset mid-code SHALL discard the partial prefix; a new code_valid is required before decoding.

Structure
REQ-030 huffman_pkg SHALL hold SYM_NUM, CODE_W, MAX_LEN defaults and the FSM state encoding, shared with the encoder.
REQ-031 One sub-module huffman_match SHALL compare a single (HC, M) entry against (sr_new, len_new); instantiated SYM_NUM times.

Verification
REQ-032 Load HC=0,2,6,14,30,31 M=1,3,7,15,31,31; bits 0 -> sym_valid, sym_data=1, sym_cnt=1.
REQ-033 Same table; bits 1,1,0 then 1,1,1,1,1 -> sym_data=3, then sym_data=6, sym_cnt=2; no err.
REQ-034 Same table with M6=0; bits 1,1,1,1,1,1 -> err pulse after 6th bit, no sym_valid, sym_cnt unchanged.
REQ-035 bits 1,1 then code_valid together with bit_in=0 -> no symbol; then bits 1,0 -> sym_data=2.
REQ-036 bit_valid before any code_valid -> no output, table_rdy=0; reset after bits 1,1,1 -> all outputs 0, state IDLE.
REQ-037 Bits 1,0 with 3 idle cycles between them -> single sym_data=2 one cycle after the second bit.
